// File: rtl/operand_pair_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : operand_pair_sequencer
// Brief   : Issues matched (activation, weight) pairs of a tile to the MAC,
//           one pair per cycle in index order.
// Revision: 1.0 - initial release
// ============================================================================
module operand_pair_sequencer #(
   parameter int BITMASK_LENGTH = 8,
   parameter int INDEX_BITWIDTH = 3,
   parameter int COUNT_BITWIDTH = 4,
   parameter int VALUE_BITWIDTH = 8
) (
   input  logic                                     clock,
   input  logic                                     reset,
   input  logic                                     i_valid,
   output logic                                     o_in_ready,
   input  logic [63:0]                              i_result,
   input  logic [BITMASK_LENGTH*VALUE_BITWIDTH-1:0] i_act_values,
   input  logic [BITMASK_LENGTH*VALUE_BITWIDTH-1:0] i_wgt_values,
   output logic                                     o_valid,
   input  logic                                     i_ready,
   output logic [VALUE_BITWIDTH-1:0]                o_act,
   output logic [VALUE_BITWIDTH-1:0]                o_wgt,
   output logic [INDEX_BITWIDTH-1:0]                o_pair_index,
   output logic                                     o_last,
   output logic                                     o_empty_tile,
   output logic                                     o_count_error
);

   localparam int c_IDX_FIELD_W = BITMASK_LENGTH * INDEX_BITWIDTH;
   localparam int c_CNT_LSB     = 2 * c_IDX_FIELD_W;
   localparam int c_USED_W      = c_CNT_LSB + COUNT_BITWIDTH;

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_ISSUE = 1'b1
   } state_t;

   state_t                    r_state;
   logic                      r_ready_en;
   logic [VALUE_BITWIDTH-1:0] r_act   [BITMASK_LENGTH];
   logic [VALUE_BITWIDTH-1:0] r_wgt   [BITMASK_LENGTH];
   logic [INDEX_BITWIDTH-1:0] r_a_idx [BITMASK_LENGTH];
   logic [INDEX_BITWIDTH-1:0] r_w_idx [BITMASK_LENGTH];
   logic [INDEX_BITWIDTH-1:0] r_beat;
   logic [INDEX_BITWIDTH-1:0] r_last_beat;
   logic                      r_empty;
   logic                      r_count_error;

   logic                      w_issue;
   logic                      w_last;
   logic                      w_accept;
   logic [COUNT_BITWIDTH-1:0] w_count;
   logic                      w_over;
   logic [INDEX_BITWIDTH-1:0] w_last_beat;
   logic                      w_unused;

   assign w_unused = ^i_result[63:c_USED_W];

   assign w_issue    = (r_state == S_ISSUE);
   assign w_last     = w_issue && (r_beat == r_last_beat);
   assign o_in_ready = r_ready_en && ((r_state == S_IDLE) || (w_last && i_ready));
   assign w_accept   = i_valid && o_in_ready;

   assign w_count = i_result[c_CNT_LSB +: COUNT_BITWIDTH];
   assign w_over  = (w_count > COUNT_BITWIDTH'(BITMASK_LENGTH));

   // BITMASK_LENGTH is 2**INDEX_BITWIDTH, so count 8 minus one wraps to 7 in
   // the narrow index width; zero-match tiles still get a single beat 0.
   assign w_last_beat = (w_count == '0) ? '0 :
                        w_over          ? INDEX_BITWIDTH'(BITMASK_LENGTH - 1) :
                                          w_count[INDEX_BITWIDTH-1:0] - INDEX_BITWIDTH'(1);

   assign o_valid       = w_issue;
   assign o_last        = w_last;
   assign o_empty_tile  = w_issue && r_empty;
   assign o_pair_index  = w_issue ? r_beat : '0;
   assign o_act         = (w_issue && !r_empty) ? r_act[r_a_idx[r_beat]] : '0;
   assign o_wgt         = (w_issue && !r_empty) ? r_wgt[r_w_idx[r_beat]] : '0;
   assign o_count_error = r_count_error;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_ready_en    <= 1'b0;
         r_beat        <= '0;
         r_last_beat   <= '0;
         r_empty       <= 1'b0;
         r_count_error <= 1'b0;
         for (int k = 0; k < BITMASK_LENGTH; k++) begin
            r_act[k]   <= '0;
            r_wgt[k]   <= '0;
            r_a_idx[k] <= '0;
            r_w_idx[k] <= '0;
         end
      end else begin
         r_ready_en <= 1'b1;
         if (w_accept) begin
            // A new tile is only accepted while idle or as the final beat retires.
            r_state     <= S_ISSUE;
            r_beat      <= '0;
            r_last_beat <= w_last_beat;
            r_empty     <= (w_count == '0);
            if (w_over) begin
               r_count_error <= 1'b1;
            end
            for (int k = 0; k < BITMASK_LENGTH; k++) begin
               r_act[k]   <= i_act_values[k*VALUE_BITWIDTH +: VALUE_BITWIDTH];
               r_wgt[k]   <= i_wgt_values[k*VALUE_BITWIDTH +: VALUE_BITWIDTH];
               r_a_idx[k] <= i_result[k*INDEX_BITWIDTH +: INDEX_BITWIDTH];
               r_w_idx[k] <= i_result[c_IDX_FIELD_W + k*INDEX_BITWIDTH +: INDEX_BITWIDTH];
            end
         end else if (w_issue && i_ready) begin
            if (w_last) begin
               r_state <= S_IDLE;
            end else begin
               r_beat <= r_beat + INDEX_BITWIDTH'(1);
            end
         end
      end
   end

endmodule
`default_nettype wire
